rr_arb_mux: RTL and testbench

//  N-to-1 merge point of the NoC datapath, the converse of the 1-to-N flit demux.

---
 rtl/rr_arb_mux_pkg.sv | 11 +
 rtl/rr_arb_mux_if.sv | 27 ++
 rtl/rr_arb_mux_arbiter.sv | 34 +++
 rtl/rr_arb_mux.sv | 106 ++++++++++
 tb/tb_rr_arb_mux.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_mux_pkg.sv
// noc_arb_pkg: shared types and helpers for the round-robin flit merge (rr_arb_mux).
package noc_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Wrapped increment of a round-robin pointer: n-1 wraps to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: per-input flit streams in, one registered flit stream out.
// slave = merge block view, master = sources/sink view.
interface rr_arb_mux_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INPUT_NUM  = 2,
  parameter int unsigned SEL_WIDTH  = $clog2(INPUT_NUM)
);
  logic [DATA_WIDTH-1:0] data_i [INPUT_NUM];
  logic [INPUT_NUM-1:0]  valid_i;
  logic [INPUT_NUM-1:0]  last_i;
  logic [INPUT_NUM-1:0]  ready_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  last_o;
  logic                  ready_i;
  logic [SEL_WIDTH-1:0]  grant_o;

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, valid_o, last_o, grant_o
  );

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, valid_o, last_o, grant_o
  );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: combinational round-robin pick; first requester scanning ptr, ptr+1, ... (wrapping).
module rr_arbiter #(
  parameter int unsigned INPUT_NUM = 2,
  parameter int unsigned SEL_WIDTH = $clog2(INPUT_NUM)
) (
  input  logic [INPUT_NUM-1:0] req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [INPUT_NUM-1:0] gnt,
  output logic [SEL_WIDTH-1:0] gnt_idx,
  output logic                 any_gnt
);

  // Scan from ptr upward, first requester wins.
  always_comb begin
    int unsigned          k;
    logic [SEL_WIDTH-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    k       = 0;
    idx     = '0;
    for (int unsigned i = 0; i < INPUT_NUM; i++) begin
      k = 32'(ptr) + i;
      if (k >= INPUT_NUM) k = k - INPUT_NUM;
      idx = SEL_WIDTH'(k);
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 round-robin flit merge with one registered output stage.
// Optional macro ARB_MUX_PKT_LOCK_EN: wormhole locking (grant held for a whole packet).
// Without it, arbitration is per flit and last_i is only forwarded to last_o.
module rr_arb_mux
  import noc_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INPUT_NUM  = 2,
  parameter int unsigned SEL_WIDTH  = $clog2(INPUT_NUM)
) (
  input logic       clk_i,
  input logic       rst_n_i,
  rr_arb_mux_if.slave bus
);

  logic [SEL_WIDTH-1:0] ptr;
  logic [INPUT_NUM-1:0] req;
  logic [INPUT_NUM-1:0] gnt;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic                 any_gnt;
  logic                 load_en;
  logic                 accept;
  logic                 win_last;

`ifdef ARB_MUX_PKT_LOCK_EN
  arb_state_t           state;
  logic [SEL_WIDTH-1:0] owner;

  // While locked only the owner may request; others see a bubble.
  always_comb begin
    req = bus.valid_i;
    if (state == ARB_LOCKED) begin
      req        = '0;
      req[owner] = bus.valid_i[owner];
    end
  end
`else
  // Every valid input competes each cycle.
  always_comb begin
    req = bus.valid_i;
  end
`endif

  rr_arbiter #(
    .INPUT_NUM (INPUT_NUM),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign load_en     = !bus.valid_o || bus.ready_i;
  // Reset gating keeps every ready_o low while rst_n_i is asserted.
  assign accept      = rst_n_i && load_en && any_gnt;
  assign win_last    = bus.last_i[gnt_idx];
  assign bus.ready_o = accept ? gnt : '0;

  // Output register: load the granted flit whenever the stage is empty or draining.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.valid_o <= 1'b0;
      bus.last_o  <= 1'b0;
      bus.data_o  <= '0;
      bus.grant_o <= '0;
    end else if (load_en) begin
      bus.valid_o <= any_gnt;
      if (any_gnt) begin
        bus.data_o  <= bus.data_i[gnt_idx];
        bus.last_o  <= win_last;
        bus.grant_o <= gnt_idx;
      end
    end
  end

`ifdef ARB_MUX_PKT_LOCK_EN
  // Packet FSM and pointer: lock on a non-last accept, advance ptr only on a tail.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr   <= '0;
      state <= ARB_IDLE;
      owner <= '0;
    end else if (accept) begin
      if (win_last) begin
        ptr   <= SEL_WIDTH'(rr_next(32'(gnt_idx), INPUT_NUM));
        state <= ARB_IDLE;
      end else if (state == ARB_IDLE) begin
        state <= ARB_LOCKED;
        owner <= gnt_idx;
      end
    end
  end
`else
  // Pointer advances past the winner on every accepted flit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= SEL_WIDTH'(rr_next(32'(gnt_idx), INPUT_NUM));
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: vector table, hand sequences and random traffic against a reference model.
// Expectations follow ARB_MUX_PKT_LOCK_EN when it is defined for the build.
module tb_rr_arb_mux;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.DATA_WIDTH(DW), .INPUT_NUM(N)) bus();

  rr_arb_mux #(.DATA_WIDTH(DW), .INPUT_NUM(N)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.valid_i = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b1;
    for (int k = 0; k < N; k++) bus.data_i[k] = '0;
  endtask

  // Leaves time at posedge+3 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       r;
    logic [3:0] exp_rdy;
    logic       exp_vo;
    logic [1:0] exp_g;
  } vec_t;
  vec_t tbl [12];

  // ---------------- scripted sources ----------------
  typedef struct {
    logic [31:0] d;
    logic        l;
    int          gap;
  } flit_t;
  typedef struct {
    logic [31:0] d;
    logic        l;
    int          g;
  } obs_t;
  flit_t q [4][$];

  task automatic run_script(input string tag);
    obs_t       exp_s [5];
    obs_t       obs [$];
    obs_t       o;
    int         gap_cnt [4];
    logic [3:0] pres;
    logic [3:0] rdy;
    int         left;
    flit_t      f;
    do_reset();
    for (int k = 0; k < N; k++) q[k].delete();
    f = '{32'h1111_0001, 1'b0, 0}; q[1].push_back(f);
    f = '{32'h1111_0002, 1'b0, 1}; q[1].push_back(f);
    f = '{32'h1111_0003, 1'b1, 0}; q[1].push_back(f);
    f = '{32'h3333_0001, 1'b0, 0}; q[3].push_back(f);
    f = '{32'h3333_0002, 1'b1, 0}; q[3].push_back(f);
`ifdef ARB_MUX_PKT_LOCK_EN
    exp_s[0] = '{32'h1111_0001, 1'b0, 1};
    exp_s[1] = '{32'h1111_0002, 1'b0, 1};
    exp_s[2] = '{32'h1111_0003, 1'b1, 1};
    exp_s[3] = '{32'h3333_0001, 1'b0, 3};
    exp_s[4] = '{32'h3333_0002, 1'b1, 3};
`else
    exp_s[0] = '{32'h1111_0001, 1'b0, 1};
    exp_s[1] = '{32'h3333_0001, 1'b0, 3};
    exp_s[2] = '{32'h1111_0002, 1'b0, 1};
    exp_s[3] = '{32'h3333_0002, 1'b1, 3};
    exp_s[4] = '{32'h1111_0003, 1'b1, 1};
`endif
    for (int k = 0; k < N; k++) gap_cnt[k] = (q[k].size() > 0) ? q[k][0].gap : 0;
    left = 5;
    for (int c = 0; c < 20 && left > 0; c++) begin
      for (int k = 0; k < N; k++) begin
        pres[k] = (q[k].size() > 0) && (gap_cnt[k] == 0);
        bus.valid_i[k] = pres[k];
        bus.data_i[k]  = pres[k] ? q[k][0].d : '0;
        bus.last_i[k]  = pres[k] ? q[k][0].l : 1'b0;
      end
      bus.ready_i = 1'b1;
      #1 rdy = bus.ready_o;
      @(posedge clk); #1;
      if (bus.valid_o) begin
        o = '{bus.data_o, bus.last_o, int'(bus.grant_o)};
        obs.push_back(o);
      end
      left = 0;
      for (int k = 0; k < N; k++) begin
        if (rdy[k]) begin
          void'(q[k].pop_front());
          if (q[k].size() > 0) gap_cnt[k] = q[k][0].gap;
        end else if (!pres[k] && gap_cnt[k] > 0) begin
          gap_cnt[k]--;
        end
        left += q[k].size();
      end
    end
    chk({tag, " drained"}, left, 0);
    chk({tag, " flit count"}, obs.size(), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      chk($sformatf("%s flit%0d grant", tag, i), obs[i].g, exp_s[i].g);
      chk($sformatf("%s flit%0d data", tag, i), obs[i].d, exp_s[i].d);
      chk($sformatf("%s flit%0d last", tag, i), obs[i].l, exp_s[i].l);
    end
    clear_inputs();
  endtask

  // ---------------- reference model ----------------
  logic        m_valid;
  logic        m_last;
  logic [31:0] m_data;
  int          m_grant;
  int          m_ptr;
  int          m_owner;
  bit          m_locked;

  function automatic int pick(input logic [3:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic run_random(input int cycles);
    logic        s_v [4];
    logic [31:0] s_d [4];
    logic        s_l [4];
    logic [3:0]  rdy;
    logic [3:0]  exp_rdy;
    logic        load;
    logic [31:0] w_d;
    logic        w_l;
    int          w;
    do_reset();
    m_valid = 1'b0; m_last = 1'b0; m_data = '0;
    m_grant = 0; m_ptr = 0; m_owner = 0; m_locked = 1'b0;
    for (int k = 0; k < N; k++) begin
      s_v[k] = 1'b0; s_d[k] = '0; s_l[k] = 1'b0;
    end
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!s_v[k] && ($urandom % 10) < 7) begin
          s_v[k] = 1'b1;
          s_d[k] = $urandom;
          s_l[k] = ($urandom % 5) < 2;
        end
        bus.valid_i[k] = s_v[k];
        bus.data_i[k]  = s_d[k];
        bus.last_i[k]  = s_l[k];
      end
      bus.ready_i = ($urandom % 4) != 0;
      #1;
      w       = pick(bus.valid_i);
      load    = !m_valid || bus.ready_i;
      exp_rdy = (load && w >= 0) ? (4'b0001 << w) : 4'b0000;
      w_d     = (w >= 0) ? s_d[w] : '0;
      w_l     = (w >= 0) ? s_l[w] : 1'b0;
      rdy     = bus.ready_o;
      chk($sformatf("rand%0d ready_o", c), rdy, exp_rdy);
      @(posedge clk); #1;
      if (load) begin
        m_valid = (w >= 0);
        if (w >= 0) begin
          m_data  = w_d;
          m_last  = w_l;
          m_grant = w;
`ifdef ARB_MUX_PKT_LOCK_EN
          if (w_l) begin
            m_locked = 1'b0;
            m_ptr    = (w + 1) % N;
          end else begin
            m_locked = 1'b1;
            m_owner  = w;
          end
`else
          m_ptr = (w + 1) % N;
`endif
        end
      end
      chk($sformatf("rand%0d valid_o", c), bus.valid_o, m_valid);
      if (m_valid) begin
        chk($sformatf("rand%0d data_o", c), bus.data_o, m_data);
        chk($sformatf("rand%0d last_o", c), bus.last_o, m_last);
        chk($sformatf("rand%0d grant_o", c), bus.grant_o, m_grant);
      end
      for (int k = 0; k < N; k++) if (rdy[k]) s_v[k] = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b0101, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[6]  = '{4'b0101, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{4'b1000, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[9]  = '{4'b0010, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[10] = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[11] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};

    clear_inputs();

    // Reset with all inputs requesting.
    #1 rst_n = 1'b0;
    bus.valid_i = 4'b1111;
    bus.last_i  = 4'b1111;
    for (int k = 0; k < N; k++) bus.data_i[k] = 32'hD000_0000 + k;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", bus.valid_o, 1'b0);
    chk("reset ready_o", bus.ready_o, 4'b0000);
    chk("reset grant_o", bus.grant_o, 2'd0);
    chk("reset data_o", bus.data_o, 32'h0);
    #1 rst_n = 1'b1;
    #1;

    // Fairness and single-flit table.
    for (int i = 0; i < 12; i++) begin
      bus.valid_i = tbl[i].v;
      bus.last_i  = tbl[i].l;
      bus.ready_i = tbl[i].r;
      #1 chk($sformatf("tbl%0d ready_o", i), bus.ready_o, tbl[i].exp_rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d valid_o", i), bus.valid_o, tbl[i].exp_vo);
      if (tbl[i].exp_vo) begin
        chk($sformatf("tbl%0d grant_o", i), bus.grant_o, tbl[i].exp_g);
        chk($sformatf("tbl%0d data_o", i), bus.data_o, 32'hD000_0000 + 32'(tbl[i].exp_g));
      end
    end

    // Backpressure on a flit from input 2.
    do_reset();
    bus.valid_i = 4'b0100; bus.last_i = 4'b0100;
    bus.data_i[2] = 32'hA5A5_0002; bus.ready_i = 1'b0;
    #1 chk("bp first ready_o", bus.ready_o, 4'b0100);
    @(posedge clk); #1;
    chk("bp valid_o", bus.valid_o, 1'b1);
    chk("bp data_o", bus.data_o, 32'hA5A5_0002);
    chk("bp grant_o", bus.grant_o, 2'd2);
    bus.data_i[2] = 32'hA5A5_0012;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp stall%0d ready_o", c), bus.ready_o, 4'b0000);
      @(posedge clk); #1;
      chk($sformatf("bp stall%0d data_o", c), bus.data_o, 32'hA5A5_0002);
      chk($sformatf("bp stall%0d valid_o", c), bus.valid_o, 1'b1);
    end
    bus.ready_i = 1'b1;
    #1 chk("bp release ready_o", bus.ready_o, 4'b0100);
    @(posedge clk); #1;
    chk("bp next data_o", bus.data_o, 32'hA5A5_0012);
    clear_inputs();

    // Packet from input 1 with a bubble, competing input 3.
    run_script("pkt");

    // Reset mid-packet after the second of three flits.
    do_reset();
    bus.valid_i = 4'b0100; bus.last_i = 4'b0000;
    bus.data_i[2] = 32'h2222_0001;
    @(posedge clk); #1;
    bus.data_i[2] = 32'h2222_0002;
    @(posedge clk); #1;
    chk("midrst flit2 data_o", bus.data_o, 32'h2222_0002);
    bus.data_i[2] = 32'h2222_0003; bus.last_i = 4'b0100;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst valid_o", bus.valid_o, 1'b0);
    chk("midrst ready_o", bus.ready_o, 4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.valid_i = 4'b1111; bus.last_i = 4'b1111;
    #1 chk("midrst first ready_o", bus.ready_o, 4'b0001);
    @(posedge clk); #1;
    chk("midrst first grant_o", bus.grant_o, 2'd0);
    chk("midrst first valid_o", bus.valid_o, 1'b1);
    clear_inputs();

    // Random traffic against the model.
    run_random(500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
